// File: rtl/adder_rr_arbiter.sv
// Round-robin front end that shares one 32-bit adder among NUM_REQ valid/ready requesters.
// Optional build macro ADDER_ARB_STATS_EN adds a saturating accepted-request counter (op_count).

module adder_32bit (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] sum_o
);
    assign sum_o = a_i + b_i;
endmodule

module adder_rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_sum,
    output logic [ID_W-1:0]       rsp_id
`ifdef ADDER_ARB_STATS_EN
    ,
    output logic [15:0]           op_count
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         sum_q, sum_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;

    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_id;
    logic                found;
    logic                can_accept;
    logic                accept;
    logic [31:0]         sel_a, sel_b, adder_sum;

    function automatic int wrap_idx(input int ptr, input int off);
        return (ptr + off) % NUM_REQ;
    endfunction

    // First valid requester after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            if (!found && req_valid[wrap_idx(int'(rr_ptr_q), off)]) begin
                grant[wrap_idx(int'(rr_ptr_q), off)] = 1'b1;
                grant_id = ID_W'(wrap_idx(int'(rr_ptr_q), off));
                found    = 1'b1;
            end
        end
    end

    assign can_accept = (state_q == IDLE) || rsp_ready;
    assign req_ready  = (can_accept && !rst) ? grant : '0;
    assign accept     = |(req_valid & req_ready);

    // grant is one-hot or zero, so an OR-mux is sufficient.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_a = sel_a | req_a[32*i +: 32];
                sel_b = sel_b | req_b[32*i +: 32];
            end
        end
    end

    adder_32bit u_adder (
        .a_i   (sel_a),
        .b_i   (sel_b),
        .sum_o (adder_sum)
    );

    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        id_d     = id_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            IDLE: if (accept) state_d = HOLD;
            HOLD: if (rsp_ready) state_d = accept ? HOLD : IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            sum_d    = adder_sum;
            id_d     = grant_id;
            rr_ptr_d = grant_id;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sum_q    <= '0;
            id_q     <= '0;
            rr_ptr_q <= ID_W'(NUM_REQ - 1);
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q  <= state_d;
            sum_q    <= sum_d;
            id_q     <= id_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign rsp_valid = (state_q == HOLD);
    assign rsp_sum   = sum_q;
    assign rsp_id    = id_q;

`ifdef ADDER_ARB_STATS_EN
    logic [15:0] op_count_q, op_count_d;

    always_comb begin
        op_count_d = op_count_q;
        if (accept && (op_count_q != 16'hFFFF)) op_count_d = op_count_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) op_count_q <= '0;
        else     op_count_q <= op_count_d;
    end

    assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed bench for adder_rr_arbiter: reference round-robin model, response scoreboard queue,
// immediate-assertion checks; op_count checks are compiled in with ADDER_ARB_STATS_EN.

module tb_adder_rr_arbiter;

    localparam int NUM_REQ = 3;
    localparam int ID_W    = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*32-1:0] req_a, req_b;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_sum;
    logic [ID_W-1:0]       rsp_id;
`ifdef ADDER_ARB_STATS_EN
    logic [15:0]           op_count;
`endif

    adder_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id)
`ifdef ADDER_ARB_STATS_EN
        ,
        .op_count  (op_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]     sum;
        logic [ID_W-1:0] id;
    } rsp_t;

    rsp_t        sb_q[$];
    logic [31:0] op_a[NUM_REQ];
    logic [31:0] op_b[NUM_REQ];

    // Reference model state
    logic            m_valid;
    logic [31:0]     m_sum;
    logic [ID_W-1:0] m_id;
    int              m_ptr;
    logic [15:0]     m_cnt;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NUM_REQ-1:0] model_grant(input logic [NUM_REQ-1:0] v, input int ptr);
        for (int off = 1; off <= NUM_REQ; off++) begin
            if (v[(ptr + off) % NUM_REQ]) return NUM_REQ'(1) << ((ptr + off) % NUM_REQ);
        end
        return '0;
    endfunction

    task automatic pack_ops();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[32*i +: 32] = op_a[i];
            req_b[32*i +: 32] = op_b[i];
        end
    endtask

    // One clock of traffic: check combinational grant, predict, then check the registered slot.
    task automatic cycle(input string tag, input logic [NUM_REQ-1:0] v, input logic rr);
        logic [NUM_REQ-1:0] g;
        rsp_t               e;
        int                 gi;
        req_valid = v;
        rsp_ready = rr;
        pack_ops();
        #1;
        g = (!m_valid || rr) ? model_grant(v, m_ptr) : '0;
        check({tag, ".req_ready"}, 32'(req_ready), 32'(g));
        if (g != '0) begin
            gi = 0;
            for (int i = 0; i < NUM_REQ; i++) if (g[i]) gi = i;
            e.sum = op_a[gi] + op_b[gi];
            e.id  = ID_W'(gi);
            sb_q.push_back(e);
            m_ptr = gi;
            if (m_cnt != 16'hFFFF) m_cnt++;
        end
        @(posedge clk);
        #1;
        if (g != '0) begin
            e       = sb_q.pop_front();
            m_valid = 1'b1;
            m_sum   = e.sum;
            m_id    = e.id;
        end else if (rr) begin
            m_valid = 1'b0;
        end
        check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(m_valid));
        if (m_valid) begin
            check({tag, ".rsp_sum"}, rsp_sum, m_sum);
            check({tag, ".rsp_id"}, 32'(rsp_id), 32'(m_id));
        end
`ifdef ADDER_ARB_STATS_EN
        check({tag, ".op_count"}, 32'(op_count), 32'(m_cnt));
`endif
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_sum   = '0;
        m_id    = '0;
        m_ptr   = NUM_REQ - 1;
        m_cnt   = '0;
        sb_q.delete();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        op_a      = '{32'd111, 32'd45, 32'd408};
        op_b      = '{32'd342, 32'd123, 32'd292};
        model_reset();

        // Reset held for three cycles; grants stay off even with requests present.
        repeat (3) @(posedge clk);
        req_valid = 3'b111;
        #1;
        check("rst.req_ready_gated", 32'(req_ready), 32'd0);
        req_valid = '0;
        rst       = 1'b0;
        #1;
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.rsp_sum", rsp_sum, 32'd0);
        check("rst.rsp_id", 32'(rsp_id), 32'd0);
        check("rst.req_ready_idle", 32'(req_ready), 32'd0);
`ifdef ADDER_ARB_STATS_EN
        check("rst.op_count", 32'(op_count), 32'd0);
`endif
        req_valid = 3'b111;
        #1;
        check("rst.first_priority", 32'(req_ready), 32'b001);
        req_valid = '0;
        @(posedge clk);
        #1;

        // Requester 0 alone: 111 + 222.
        op_a[0] = 32'd111;
        op_b[0] = 32'd222;
        cycle("single0", 3'b001, 1'b1);
        check("single0.sum333", rsp_sum, 32'd333);

        // Move the pointer to 2 so the rotation starts at requester 0.
        op_a[0] = 32'd111;
        op_b[0] = 32'd342;
        cycle("single2", 3'b100, 1'b1);

        // All valid: grants 0,1,2,0,1,2,0 back-to-back.
        for (int k = 0; k < 7; k++) cycle("rr_all", 3'b111, 1'b1);
        check("rr_all.last_sum453", rsp_sum, 32'd453);

        // Backpressure: slot held with 453, no grants, outputs stable.
        for (int k = 0; k < 5; k++) cycle("hold", 3'b111, 1'b0);
        check("hold.sum_stable", rsp_sum, 32'd453);
        cycle("release", 3'b111, 1'b1);

        // Drain with no requests, then confirm priority is unchanged.
        cycle("drain", 3'b000, 1'b1);
        cycle("after_drain", 3'b111, 1'b1);

        // Wrap-around sum on a single requester granted every cycle.
        op_a[1] = 32'hFFFF_FFFF;
        op_b[1] = 32'h0000_0002;
        for (int k = 0; k < 3; k++) cycle("wrap", 3'b010, 1'b1);
        check("wrap.sum1", rsp_sum, 32'h0000_0001);

        // Requester drops valid while blocked: no grant issued for it.
        cycle("drop_setup", 3'b001, 1'b0);
        cycle("drop_blocked", 3'b100, 1'b0);
        cycle("drop_gone", 3'b000, 1'b1);

        // Asynchronous reset with a response pending.
        cycle("pre_rst", 3'b111, 1'b0);
        req_valid = 3'b111;
        rsp_ready = 1'b1;
        rst       = 1'b1;
        #1;
        check("midrst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst.req_ready", 32'(req_ready), 32'd0);
`ifdef ADDER_ARB_STATS_EN
        check("midrst.op_count", 32'(op_count), 32'd0);
`endif
        model_reset();
        @(posedge clk);
        #1;
        req_valid = '0;
        rst       = 1'b0;
        cycle("post_rst", 3'b111, 1'b1);

`ifdef ADDER_ARB_STATS_EN
        // Saturation: keep requester 0 streaming for 70000 accepts.
        req_valid = 3'b001;
        rsp_ready = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        check("sat.op_count", 32'(op_count), 32'h0000_FFFF);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
